instruction_fetch_unit: RTL

// Sequences the instruction memory: owns the PC, drives the 12-bit fetch address and captures
// 19-bit instructions into a small prefetch queue. Hands {instr, pc} to decode via valid/ready.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 69 ++++++
 rtl/instruction_fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, FSM state type and queue entry layout for the instruction fetch unit.
package cpu_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries with a registered head and flush.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         valid,
  output logic [PW:0]  count
);

  fetch_entry_t      mem [QDEPTH];
  fetch_entry_t      head_q;
  fetch_entry_t      head_d;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_next;
  logic [PW:0]       count_q;
  logic              do_pop;

  assign do_pop  = pop & (count_q != '0);
  assign rd_next = rd_ptr + PW'(1);

  // The head register always mirrors the entry that will be oldest after this cycle.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count_q > (PW+1)'(1)) head_d = mem[rd_next];
      else if (push)            head_d = din;
    end else if ((count_q == '0) && push) begin
      head_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_next;
      if (push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (!push && do_pop) count_q <= count_q - (PW+1)'(1);
    end
  end

  assign head  = head_q;
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC and fetch FSM, feeds the prefetch queue and presents {instr, pc} to decode.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic [15:0]        fetch_count,
  output fetch_state_t       state
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       fetch_count_q;
  logic              halted_q;
  logic              push;
  logic              pop;
  logic              q_valid;
  logic [PW:0]       q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_din;

  // Valid/ready: an entry transfers on every cycle where out_valid and out_ready are both high;
  // out_valid never depends on out_ready, and a redirect cannot cancel a transfer already accepted.
  assign pop  = q_valid & out_ready;
  assign push = (state_q == FETCH) & ~redirect_valid & ~halt_req &
                ((q_count < (PW+1)'(QDEPTH)) | pop);

  assign q_din.instr = imem_instr;
  assign q_din.pc    = pc_q;

  fetch_queue #(.QDEPTH(QDEPTH), .PW(PW)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .head  (q_head),
    .valid (q_valid),
    .count (q_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (!redirect_valid && halt_req) state_d = HALT;
      HALT:    if (redirect_valid) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
      if (redirect_valid) pc_q <= redirect_pc;
      else if (push)      pc_q <= pc_q + ADDR_W'(1);
      if (push) fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = q_valid;
  assign out_instr   = q_head.instr;
  assign out_pc      = q_head.pc;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
  assign state       = state_q;

endmodule
